// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed little-endian program image over UART 8N1 and writes it into the instruction ROM.
// Latency: rom_wren asserts 2 cycles after the stop-bit sample of each word's 4th byte; cpu_reset_n rises the cycle after the last write.
// Backpressure: none; the ROM write port always accepts, and the UART cannot be stalled. Bytes arriving in DONE/ERROR are ignored.
//
// Ports: clk, reset_n (async active-low), uart_rxd (async serial in, idle high),
//        rom_wren / rom_write_address / rom_write_data (ROM write port),
//        cpu_reset_n (CPU core reset), loading / done / error (status).
module uart_program_loader #(
    parameter int CLKS_PER_BIT      = 87,
    parameter int ROM_ADDRESS_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         uart_rxd,
    output logic                         rom_wren,
    output logic [ROM_ADDRESS_WIDTH-1:0] rom_write_address,
    output logic [31:0]                  rom_write_data,
    output logic                         cpu_reset_n,
    output logic                         loading,
    output logic                         done,
    output logic                         error
);
    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam int              IW       = ROM_ADDRESS_WIDTH - 2;
    localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [32:0]     CAPACITY = 33'(1) << IW;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN, L_WORD, L_WRITE, L_DONE, L_ERROR} ld_state_t;

    // ---------------- UART receiver ----------------
    logic            rxd_meta, rxd_sync, rxd_prev;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      rx_shift;
    logic            byte_valid, frame_err;

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rxd_prev && !rxd_sync) rx_next = RX_START;
            // Mid-start re-sample: a line already back high was a glitch.
            RX_START: if (clk_cnt == HALF_END) rx_next = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (clk_cnt == BIT_END && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (clk_cnt == BIT_END) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta   <= 1'b1;
            rxd_sync   <= 1'b1;
            rxd_prev   <= 1'b1;
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxd_meta   <= uart_rxd;
            rxd_sync   <= rxd_meta;
            rxd_prev   <= rxd_sync;
            rx_state   <= rx_next;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_next != rx_state || (rx_state == RX_DATA && clk_cnt == BIT_END))
                clk_cnt <= '0;
            else if (rx_state != RX_IDLE)
                clk_cnt <= clk_cnt + CW'(1);
            if (rx_state == RX_IDLE)
                bit_cnt <= '0;
            if (rx_state == RX_DATA && clk_cnt == BIT_END) begin
                rx_shift <= {rxd_sync, rx_shift[7:1]};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (rx_state == RX_STOP && clk_cnt == BIT_END) begin
                byte_valid <= rxd_sync;
                frame_err  <= !rxd_sync;
            end
        end
    end

    // ---------------- Loader ----------------
    ld_state_t       ld_state, ld_next;
    logic [1:0]      byte_cnt;
    logic [31:0]     n_q, word_q;
    logic [IW-1:0]   idx;
    logic            loading_q;
    logic [31:0]     n_next, word_next;
    logic            last_byte, idx_is_last;

    assign n_next      = {rx_shift, n_q[31:8]};
    assign word_next   = {rx_shift, word_q[31:8]};
    assign last_byte   = (byte_cnt == 2'd3);
    assign idx_is_last = (32'(idx) == n_q - 32'd1);

    always_comb begin
        ld_next = ld_state;
        if (frame_err && ld_state != L_DONE) begin
            ld_next = L_ERROR;
        end else begin
            unique case (ld_state)
                L_LEN:
                    if (byte_valid && last_byte) begin
                        if (n_next == 32'd0)                 ld_next = L_DONE;
                        else if ({1'b0, n_next} > CAPACITY) ld_next = L_ERROR;
                        else                                 ld_next = L_WORD;
                    end
                L_WORD:  if (byte_valid && last_byte) ld_next = L_WRITE;
                L_WRITE: ld_next = idx_is_last ? L_DONE : L_WORD;
                default: ld_next = ld_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_state          <= L_LEN;
            byte_cnt          <= '0;
            n_q               <= '0;
            word_q            <= '0;
            idx               <= '0;
            loading_q         <= 1'b0;
            rom_write_address <= '0;
            rom_write_data    <= '0;
        end else begin
            ld_state <= ld_next;
            if (rx_state == RX_START && rx_next == RX_DATA)
                loading_q <= 1'b1;
            if (byte_valid && (ld_state == L_LEN || ld_state == L_WORD))
                byte_cnt <= byte_cnt + 2'd1;
            if (byte_valid && ld_state == L_LEN)
                n_q <= n_next;
            if (byte_valid && ld_state == L_WORD) begin
                word_q <= word_next;
                // Address/data are loaded as the FSM enters WRITE and then held.
                if (last_byte) begin
                    rom_write_data    <= word_next;
                    rom_write_address <= {idx, 2'b00};
                end
            end
            if (ld_state == L_WRITE && !idx_is_last)
                idx <= idx + IW'(1);
        end
    end

    assign rom_wren    = (ld_state == L_WRITE);
    assign done        = (ld_state == L_DONE);
    assign error       = (ld_state == L_ERROR);
    assign cpu_reset_n = done;
    assign loading     = loading_q && !done && !error;
endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        uart_rxd;
    logic        rom_wren;
    logic [9:0]  rom_write_address;
    logic [31:0] rom_write_data;
    logic        cpu_reset_n, loading, done, error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cyc = -1;
    int wr_cyc = -1;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    logic [7:0] img1 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                              8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'ha0, 8'h00};

    uart_program_loader #(.CLKS_PER_BIT(16), .ROM_ADDRESS_WIDTH(10)) dut (
        .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd),
        .rom_wren(rom_wren), .rom_write_address(rom_write_address),
        .rom_write_data(rom_write_data), .cpu_reset_n(cpu_reset_n),
        .loading(loading), .done(done), .error(error));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write scoreboard capture; a write while done/error is set is an immediate failure.
    always @(negedge clk) begin
        if (reset_n) begin
            if (done && done_cyc < 0) done_cyc = cyc;
            if (rom_wren) begin
                wr_addr.push_back(32'(rom_write_address));
                wr_data.push_back(rom_write_data);
                wr_cyc = cyc;
                tests++;
                assert (!(done || error)) else begin
                    fails++;
                    $error("FAIL wren_while_flag: observed done=%0b error=%0b expected 0/0", done, error);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) uart_rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (16) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_img1();
        for (int i = 0; i < 12; i++) send_byte(img1[i], 1'b1);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        done_cyc = -1;
        wr_cyc   = -1;
        reset_n  = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_wren", 32'(rom_wren), 0);
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 0);
        check("rst_flags", {29'd0, loading, done, error}, 0);
        check("rst_addr", 32'(rom_write_address), 0);
        check("rst_data", rom_write_data, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: two-word image
        send_byte(img1[0], 1'b1);
        check("t1_loading", 32'(loading), 1);
        check("t1_cpu_held", 32'(cpu_reset_n), 0);
        for (int i = 1; i < 12; i++) send_byte(img1[i], 1'b1);
        repeat (5) @(negedge clk);
        check("t1_nwr", wr_addr.size(), 2);
        check("t1_a0", wr_addr[0], 32'h0);
        check("t1_d0", wr_data[0], 32'h0000_0013);
        check("t1_a1", wr_addr[1], 32'h4);
        check("t1_d1", wr_data[1], 32'h00a0_0093);
        check("t1_done_lat", 32'(done_cyc - wr_cyc), 1);
        check("t1_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b1010);
        check("t1_hold_data", rom_write_data, 32'h00a0_0093);

        // Test 2: empty image
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        repeat (5) @(negedge clk);
        check("t2_nwr", wr_addr.size(), 0);
        check("t2_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b1010);

        // Test 3: framing error on 3rd word byte, then a valid frame is ignored
        do_reset();
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (5) @(negedge clk);
        check("t3_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b0001);
        send_byte(8'h44, 1'b1);
        repeat (20) @(negedge clk);
        check("t3_after_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b0001);
        check("t3_nwr", wr_addr.size(), 0);

        // Test 4: length 257 exceeds 256-word capacity
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (5) @(negedge clk);
        check("t4_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b0001);
        check("t4_nwr", wr_addr.size(), 0);

        // Test 5: 6-cycle glitch, then a one-word load
        do_reset();
        uart_rxd = 1'b0;
        repeat (6) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("t5_glitch_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b0000);
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_byte(8'hef, 1'b1);
        send_byte(8'hbe, 1'b1);
        send_byte(8'had, 1'b1);
        send_byte(8'hde, 1'b1);
        repeat (5) @(negedge clk);
        check("t5_nwr", wr_addr.size(), 1);
        check("t5_a0", wr_addr[0], 32'h0);
        check("t5_d0", wr_data[0], 32'hdead_beef);
        check("t5_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b1010);

        // Test 6: reset mid-word, then full reload
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img1[i], 1'b1);
        check("t6_loading_pre", 32'(loading), 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b0000);
        check("t6_rst_wren", 32'(rom_wren), 0);
        check("t6_rst_addr", 32'(rom_write_address), 0);
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        done_cyc = -1;
        wr_cyc   = -1;
        reset_n  = 1'b1;
        repeat (3) @(negedge clk);
        send_img1();
        check("t6_nwr", wr_addr.size(), 2);
        check("t6_a0", wr_addr[0], 32'h0);
        check("t6_d0", wr_data[0], 32'h0000_0013);
        check("t6_a1", wr_addr[1], 32'h4);
        check("t6_d1", wr_data[1], 32'h00a0_0093);
        check("t6_status", {28'd0, cpu_reset_n, loading, done, error}, 32'b1010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
